// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction ROM port, IF/ID outputs and redirect/stall inputs.
// Handshake: stall_in is decode's not-ready. A word in IF/ID is consumed on a cycle with
// id_valid_out=1 and stall_in=0. While stall_in=1 the IF/ID register holds its contents.
interface fetch_unit_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  stall_in;
   logic                  redirect_valid_in;
   logic [1:0]            redirect_kind_in;
   logic [15:0]           branch_imm_in;
   logic [25:0]           jump_index_in;
   logic [ADDR_WIDTH-1:0] jump_reg_in;
   logic [ADDR_WIDTH-1:0] imem_addr_out;
   logic                  imem_rden_out;
   logic [31:0]           imem_data_in;
   logic [31:0]           id_inst_out;
   logic [ADDR_WIDTH-1:0] id_pc_out;
   logic [ADDR_WIDTH-1:0] id_pc_plus4_out;
   logic                  id_valid_out;
   logic                  misalign_out;
   logic [1:0]            fsm_state_out;

   modport master (
      input  stall_in, redirect_valid_in, redirect_kind_in, branch_imm_in,
             jump_index_in, jump_reg_in, imem_data_in,
      output imem_addr_out, imem_rden_out, id_inst_out, id_pc_out,
             id_pc_plus4_out, id_valid_out, misalign_out, fsm_state_out
   );

   modport slave (
      output stall_in, redirect_valid_in, redirect_kind_in, branch_imm_in,
             jump_index_in, jump_reg_in, imem_data_in,
      input  imem_addr_out, imem_rden_out, id_inst_out, id_pc_out,
             id_pc_plus4_out, id_valid_out, misalign_out, fsm_state_out
   );
endinterface

// File: rtl/fetch_unit.sv
// Pipelined MIPS fetch stage: PC, one-cycle ROM, IF/ID register, one-entry skid buffer.
// FETCH_DELAY_SLOT_EN keeps the in-flight word as a branch delay slot instead of squashing it.
module fetch_unit #(
   parameter int          ADDR_WIDTH = 32,
   parameter logic [31:0] RESET_PC   = 32'h00400000
) (
   input logic          clock,
   input logic          reset,
   fetch_unit_if.master bus
);

   localparam logic [1:0] ST_RUN     = 2'b00;
   localparam logic [1:0] ST_STALL   = 2'b01;
   localparam logic [1:0] ST_RELEASE = 2'b10;

`ifdef FETCH_DELAY_SLOT_EN
   localparam bit DELAY_SLOT = 1'b1;
`else
   localparam bit DELAY_SLOT = 1'b0;
`endif

   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic                  r_inflight;
   logic [ADDR_WIDTH-1:0] r_inflight_pc;
   logic                  r_skid_valid;
   logic [31:0]           r_skid_inst;
   logic [ADDR_WIDTH-1:0] r_skid_pc;
   logic [31:0]           r_id_inst;
   logic [ADDR_WIDTH-1:0] r_id_pc;
   logic [ADDR_WIDTH-1:0] r_id_pc_plus4;
   logic                  r_id_valid;
   logic                  r_misalign;

   logic                  w_take;
   logic                  w_issue;
   logic [ADDR_WIDTH-1:0] w_branch_off;
   logic [ADDR_WIDTH-1:0] w_jump_target;
   logic [ADDR_WIDTH-1:0] w_target_raw;
   logic [ADDR_WIDTH-1:0] w_target;
   logic                  w_misalign_raw;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [1:0]            w_state;

   // The mode is decided by this cycle's stall and whether the skid holds a word.
   always_comb begin
      w_state = ST_RUN;
      if (bus.stall_in)
         w_state = ST_STALL;
      else if (r_skid_valid)
         w_state = ST_RELEASE;
   end

   assign w_take = bus.redirect_valid_in && r_id_valid && !bus.stall_in &&
                   (bus.redirect_kind_in != 2'b11);
   assign w_issue = !bus.stall_in;

   assign w_branch_off = ADDR_WIDTH'({{14{bus.branch_imm_in[15]}}, bus.branch_imm_in, 2'b00});

   generate
      if (ADDR_WIDTH > 28) begin : g_jump_wide
         assign w_jump_target = {r_id_pc_plus4[ADDR_WIDTH-1:28], bus.jump_index_in, 2'b00};
      end else begin : g_jump_narrow
         assign w_jump_target = {bus.jump_index_in, 2'b00};
      end
   endgenerate

   always_comb begin
      w_target_raw = bus.jump_reg_in;
      case (bus.redirect_kind_in)
         2'b00:   w_target_raw = r_id_pc_plus4 + w_branch_off;
         2'b01:   w_target_raw = w_jump_target;
         default: w_target_raw = bus.jump_reg_in;
      endcase
   end

   assign w_misalign_raw = |w_target_raw[1:0];
   assign w_target       = {w_target_raw[ADDR_WIDTH-1:2], 2'b00};
   assign w_addr         = w_take ? w_target : r_fetch_pc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC[ADDR_WIDTH-1:0];
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_skid_valid  <= 1'b0;
         r_skid_inst   <= '0;
         r_skid_pc     <= '0;
         r_id_inst     <= '0;
         r_id_pc       <= '0;
         r_id_pc_plus4 <= '0;
         r_id_valid    <= 1'b0;
         r_misalign    <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_fetch_pc    <= w_addr + ADDR_WIDTH'(4);
            r_inflight_pc <= w_addr;
         end
         if (w_take && w_misalign_raw)
            r_misalign <= 1'b1;
         if (w_state == ST_STALL) begin
            if (r_inflight) begin
               r_skid_valid <= 1'b1;
               r_skid_inst  <= bus.imem_data_in;
               r_skid_pc    <= r_inflight_pc;
            end
         end else begin
            r_skid_valid <= 1'b0;
            // Without delay slots the word behind a taken redirect (in flight or skidded) dies here.
            if (w_take && !DELAY_SLOT) begin
               r_id_valid <= 1'b0;
            end else if (w_state == ST_RELEASE) begin
               r_id_valid    <= 1'b1;
               r_id_inst     <= r_skid_inst;
               r_id_pc       <= r_skid_pc;
               r_id_pc_plus4 <= r_skid_pc + ADDR_WIDTH'(4);
            end else if (r_inflight) begin
               r_id_valid    <= 1'b1;
               r_id_inst     <= bus.imem_data_in;
               r_id_pc       <= r_inflight_pc;
               r_id_pc_plus4 <= r_inflight_pc + ADDR_WIDTH'(4);
            end else begin
               r_id_valid <= 1'b0;
            end
         end
      end
   end

   assign bus.imem_addr_out   = w_addr;
   assign bus.imem_rden_out   = !reset && !bus.stall_in;
   assign bus.id_inst_out     = r_id_inst;
   assign bus.id_pc_out       = r_id_pc;
   assign bus.id_pc_plus4_out = r_id_pc_plus4;
   assign bus.id_valid_out    = r_id_valid;
   assign bus.misalign_out    = r_misalign;
   assign bus.fsm_state_out   = w_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM returns its own address, accepted IF/ID words are
// matched against an expected-PC queue, timing and sticky flags are checked inline.
module tb_fetch_unit;

   localparam logic [1:0] S_RUN     = 2'b00;
   localparam logic [1:0] S_STALL   = 2'b01;
   localparam logic [1:0] S_RELEASE = 2'b10;

   logic clock;
   logic reset;
   logic [31:0] rom_q;
   logic [31:0] exp_q[$];
   int checks;
   int errors;

   fetch_unit_if #(.ADDR_WIDTH(32)) ifc ();

   fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h00400000)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc)
   );

   // clock / ROM model
   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_ff @(posedge clock) begin
      if (ifc.imem_rden_out) rom_q <= ifc.imem_addr_out;
   end
   assign ifc.imem_data_in = rom_q;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic st, input logic rv, input logic [1:0] kd,
                        input logic [15:0] im, input logic [25:0] ix, input logic [31:0] jr);
      ifc.stall_in          = st;
      ifc.redirect_valid_in = rv;
      ifc.redirect_kind_in  = kd;
      ifc.branch_imm_in     = im;
      ifc.jump_index_in     = ix;
      ifc.jump_reg_in       = jr;
   endtask

   // A word is consumed when it is valid and decode is not stalling.
   task automatic sb_check(input logic st);
      logic [31:0] e;
      if (ifc.id_valid_out === 1'b1 && !st) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected observed=%h expected=none", ifc.id_pc_out);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pc", ifc.id_pc_out, e);
            chk("sb_inst", ifc.id_inst_out, e);
            chk("sb_pc_plus4", ifc.id_pc_plus4_out, e + 32'd4);
         end
      end
   endtask

   task automatic cyc(input logic st, input logic rv, input logic [1:0] kd,
                      input logic [15:0] im, input logic [25:0] ix, input logic [31:0] jr);
      @(negedge clock);
      drive(st, rv, kd, im, ix, jr);
      #1;
      sb_check(st);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      drive(1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
      repeat (2) @(negedge clock);
      #1;
      chk("rst_id_valid", 32'(ifc.id_valid_out), 32'd0);
      chk("rst_id_pc", ifc.id_pc_out, 32'd0);
      chk("rst_id_inst", ifc.id_inst_out, 32'd0);
      chk("rst_id_pc4", ifc.id_pc_plus4_out, 32'd0);
      chk("rst_misalign", 32'(ifc.misalign_out), 32'd0);
      chk("rst_rden", 32'(ifc.imem_rden_out), 32'd0);

      // reset release and sequential stream
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("first_rden", 32'(ifc.imem_rden_out), 32'd1);
      chk("first_addr", ifc.imem_addr_out, 32'h00400000);
      exp_q.push_back(32'h00400000);
      exp_q.push_back(32'h00400004);
      exp_q.push_back(32'h00400008);
      idle();
      chk("first_latency_bubble", 32'(ifc.id_valid_out), 32'd0);
      idle();
      chk("first_valid", 32'(ifc.id_valid_out), 32'd1);
      idle();

      // branch at 0x00400008, imm 3 -> 0x00400018
`ifdef FETCH_DELAY_SLOT_EN
      exp_q.push_back(32'h0040000C);
`endif
      exp_q.push_back(32'h00400018);
      exp_q.push_back(32'h0040001C);
      exp_q.push_back(32'h00400020);
      exp_q.push_back(32'h00400024);
      exp_q.push_back(32'h00400028);
      cyc(1'b0, 1'b1, 2'b00, 16'h0003, 26'h0, 32'h0);
      chk("branch_addr", ifc.imem_addr_out, 32'h00400018);
      idle();
`ifndef FETCH_DELAY_SLOT_EN
      chk("branch_bubble", 32'(ifc.id_valid_out), 32'd0);
`endif
      idle();
      chk("branch_misalign", 32'(ifc.misalign_out), 32'd0);
      idle();

      // three-cycle stall with the skid filling on the first
      cyc(1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
      chk("stall_rden0", 32'(ifc.imem_rden_out), 32'd0);
      chk("stall_state", 32'(ifc.fsm_state_out), 32'(S_STALL));
      cyc(1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
      chk("stall_rden1", 32'(ifc.imem_rden_out), 32'd0);
      chk("stall_hold_pc", ifc.id_pc_out, 32'h00400020);
      cyc(1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
      chk("stall_rden2", 32'(ifc.imem_rden_out), 32'd0);
      idle();
      chk("release_state", 32'(ifc.fsm_state_out), 32'(S_RELEASE));
      chk("release_addr", ifc.imem_addr_out, 32'h00400028);
      idle();
      chk("run_state", 32'(ifc.fsm_state_out), 32'(S_RUN));

      // jr to a misaligned target: first attempt under stall is ignored
      cyc(1'b1, 1'b1, 2'b10, 16'h0, 26'h0, 32'h00400102);
      chk("jr_stall_rden", 32'(ifc.imem_rden_out), 32'd0);
`ifdef FETCH_DELAY_SLOT_EN
      exp_q.push_back(32'h0040002C);
`endif
      exp_q.push_back(32'h00400100);
      exp_q.push_back(32'h00400104);
      exp_q.push_back(32'h00400108);
      cyc(1'b0, 1'b1, 2'b10, 16'h0, 26'h0, 32'h00400102);
      chk("jr_ignored_misalign", 32'(ifc.misalign_out), 32'd0);
      chk("jr_addr", ifc.imem_addr_out, 32'h00400100);
      idle();
      chk("jr_misalign_set", 32'(ifc.misalign_out), 32'd1);
`ifndef FETCH_DELAY_SLOT_EN
      chk("jr_bubble", 32'(ifc.id_valid_out), 32'd0);
`endif
      idle();
      idle();
      chk("misalign_sticky", 32'(ifc.misalign_out), 32'd1);

      // reset mid-stream with the skid holding a word
      cyc(1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
      cyc(1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
      chk("pre_reset_state", 32'(ifc.fsm_state_out), 32'(S_STALL));
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(ifc.id_valid_out), 32'd0);
      chk("async_rst_misalign", 32'(ifc.misalign_out), 32'd0);
      chk("async_rst_pc", ifc.id_pc_out, 32'd0);
      chk("async_rst_rden", 32'(ifc.imem_rden_out), 32'd0);
      exp_q.delete();
      @(negedge clock);
      @(negedge clock);
      drive(1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'h0);
      reset = 1'b0;
      #1;
      chk("restart_addr", ifc.imem_addr_out, 32'h00400000);
      chk("restart_rden", 32'(ifc.imem_rden_out), 32'd1);

      // restart, then a J-type jump and a reserved-kind redirect
      exp_q.push_back(32'h00400000);
      exp_q.push_back(32'h00400004);
`ifdef FETCH_DELAY_SLOT_EN
      exp_q.push_back(32'h00400008);
`endif
      exp_q.push_back(32'h00400140);
      exp_q.push_back(32'h00400144);
      exp_q.push_back(32'h00400148);
      idle();
      chk("restart_bubble", 32'(ifc.id_valid_out), 32'd0);
      idle();
      cyc(1'b0, 1'b1, 2'b01, 16'h0, 26'h0100050, 32'h0);
      chk("jump_addr", ifc.imem_addr_out, 32'h00400140);
      idle();
`ifndef FETCH_DELAY_SLOT_EN
      chk("jump_bubble", 32'(ifc.id_valid_out), 32'd0);
`endif
      cyc(1'b0, 1'b1, 2'b11, 16'h0010, 26'h0, 32'h0);
      chk("reserved_kind_addr", ifc.imem_addr_out, 32'h00400148);
      idle();
      idle();
      chk("final_misalign", 32'(ifc.misalign_out), 32'd0);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
